// File: rtl/axi_axis2bram_pkg.sv
// Shared definitions for the stream/BRAM buffer stages: FSM state encoding
// and the byte-count to BRAM-word depth conversion.
package axi_axis2bram_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RECV    = 2'd1,
      S_DISCARD = 2'd2
   } state_t;

   // Whole BRAM words contained in size_bytes; a trailing partial word is dropped.
   function automatic logic [63:0] bytes_to_depth(input logic [63:0] size_bytes,
                                                  input int unsigned word_bits);
      return (size_bytes << 3) / 64'(word_bits);
   endfunction

endpackage

// File: rtl/axi_axis2bram.sv
// AXI4-Stream slave that writes a fixed-length burst into a BRAM write port.
// Streams that end early or run past the programmed depth raise a sticky
// error; excess beats are accepted and dropped.
module axi_axis2bram
   import axi_axis2bram_pkg::*;
#(
   parameter int unsigned AXI_DATA_WIDTH      = 128,
   parameter int unsigned AXI_XFER_SIZE_WIDTH = 32,
   parameter int unsigned BRAM_ADDR_WIDTH     = 32,
   parameter int unsigned BRAM_DATA_WIDTH     = 128
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           i_as2b_start,
   output logic                           o_as2b_done,
   output logic                           o_as2b_err,
   input  logic [AXI_XFER_SIZE_WIDTH-1:0] i_as2b_data_size_bytes,
   input  logic                           s_axis_tvalid,
   output logic                           s_axis_tready,
   input  logic [AXI_DATA_WIDTH-1:0]      s_axis_tdata,
   input  logic                           s_axis_tlast,
   output logic                           o_as2b_wren,
   output logic [BRAM_ADDR_WIDTH-1:0]     o_as2b_wraddr,
   output logic [BRAM_DATA_WIDTH-1:0]     o_as2b_wrdata
);

   // One extra bit so a depth of exactly 2^BRAM_ADDR_WIDTH words is representable.
   localparam int unsigned DEPTH_W = BRAM_ADDR_WIDTH + 1;

   state_t               state, state_nxt;
   logic [DEPTH_W-1:0]   depth_calc;
   logic [DEPTH_W-1:0]   depth;
   logic [DEPTH_W-1:0]   cnt;
   logic                 last_word;
   logic                 start_ok;
   logic                 wr_beat;
   logic                 err_set;

   assign depth_calc  = DEPTH_W'(bytes_to_depth(64'(i_as2b_data_size_bytes), BRAM_DATA_WIDTH));
   assign last_word   = (cnt == depth - DEPTH_W'(1));
   assign o_as2b_done = (state == S_IDLE) && !o_as2b_wren;

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode plus per-cycle strobes (tready never looks at tvalid)
   always_comb begin
      state_nxt     = state;
      s_axis_tready = 1'b0;
      start_ok      = 1'b0;
      wr_beat       = 1'b0;
      err_set       = 1'b0;
      case (state)
         S_IDLE: begin
            if (i_as2b_start && (depth_calc != '0)) begin
               start_ok  = 1'b1;
               state_nxt = S_RECV;
            end
         end
         S_RECV: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid) begin
               wr_beat = 1'b1;
               if (last_word) begin
                  if (s_axis_tlast) begin
                     state_nxt = S_IDLE;
                  end else begin
                     err_set   = 1'b1;
                     state_nxt = S_DISCARD;
                  end
               end else if (s_axis_tlast) begin
                  err_set   = 1'b1;
                  state_nxt = S_IDLE;
               end
            end
         end
         S_DISCARD: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid && s_axis_tlast) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Depth/count bookkeeping, sticky error and the registered BRAM write stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         depth         <= '0;
         cnt           <= '0;
         o_as2b_err    <= 1'b0;
         o_as2b_wren   <= 1'b0;
         o_as2b_wraddr <= '0;
         o_as2b_wrdata <= '0;
      end else begin
         o_as2b_wren <= wr_beat;
         if (start_ok) begin
            depth      <= depth_calc;
            cnt        <= '0;
            o_as2b_err <= 1'b0;
         end else if (err_set) begin
            o_as2b_err <= 1'b1;
         end
         if (wr_beat) begin
            o_as2b_wraddr <= cnt[BRAM_ADDR_WIDTH-1:0];
            o_as2b_wrdata <= s_axis_tdata;
            cnt           <= cnt + DEPTH_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_axi_axis2bram.sv
// Testbench for axi_axis2bram: directed scenarios plus randomized bursts,
// checked every cycle against a beat-index reference model.
module tb_axi_axis2bram;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic         done;
   logic         err;
   logic [31:0]  size;
   logic         tvalid;
   logic         tready;
   logic [127:0] tdata;
   logic         tlast;
   logic         wren;
   logic [31:0]  wraddr;
   logic [127:0] wrdata;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: transfer in progress, beats seen, words expected
   bit           mdl_busy    = 1'b0;
   bit           mdl_discard = 1'b0;
   bit           mdl_err     = 1'b0;
   longint       mdl_depth   = 0;
   longint       mdl_idx     = 0;
   bit           exp_wren    = 1'b0;
   logic [31:0]  exp_addr    = '0;
   logic [127:0] exp_data    = '0;

   axi_axis2bram dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .i_as2b_start           (start),
      .o_as2b_done            (done),
      .o_as2b_err             (err),
      .i_as2b_data_size_bytes (size),
      .s_axis_tvalid          (tvalid),
      .s_axis_tready          (tready),
      .s_axis_tdata           (tdata),
      .s_axis_tlast           (tlast),
      .o_as2b_wren            (wren),
      .o_as2b_wraddr          (wraddr),
      .o_as2b_wrdata          (wrdata)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_wren"},   128'(wren),   128'(0));
      chk({tag, "_wraddr"}, 128'(wraddr), 128'(0));
      chk({tag, "_wrdata"}, wrdata,       128'(0));
      chk({tag, "_err"},    128'(err),    128'(0));
      chk({tag, "_tready"}, 128'(tready), 128'(0));
      chk({tag, "_done"},   128'(done),   128'(1));
   endtask

   // One clock cycle: check what the last edge produced, then drive this cycle
   // and advance the model by what the coming edge must do.
   task automatic step(input logic st, input logic [31:0] sz, input logic v, input logic l);
      logic [127:0] d;
      longint       dep;
      @(negedge clk);
      chk("wren", 128'(wren), 128'(exp_wren));
      if (exp_wren) begin
         chk("wraddr", 128'(wraddr), 128'(exp_addr));
         chk("wrdata", wrdata, exp_data);
      end
      chk("tready", 128'(tready), 128'(mdl_busy));
      chk("err",    128'(err),    128'(mdl_err));
      chk("done",   128'(done),   128'(!mdl_busy && !exp_wren));

      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      start  = st;
      size   = sz;
      tvalid = v;
      tdata  = d;
      tlast  = l;

      exp_wren = 1'b0;
      if (!mdl_busy) begin
         dep = (longint'(sz) * 8) / 128;
         if (st && dep != 0) begin
            mdl_busy    = 1'b1;
            mdl_discard = 1'b0;
            mdl_err     = 1'b0;
            mdl_depth   = dep;
            mdl_idx     = 0;
         end
      end else if (v) begin
         if (mdl_discard) begin
            if (l) mdl_busy = 1'b0;
         end else begin
            exp_wren = 1'b1;
            exp_addr = 32'(mdl_idx);
            exp_data = d;
            if (mdl_idx == mdl_depth - 1) begin
               if (l) mdl_busy = 1'b0;
               else begin
                  mdl_err     = 1'b1;
                  mdl_discard = 1'b1;
               end
            end else if (l) begin
               mdl_err  = 1'b1;
               mdl_busy = 1'b0;
            end
            mdl_idx++;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 1'b0);
   endtask

   // Burst of nb beats presented with tvalid randomly gapped, tlast on beat nb
   task automatic burst(input logic [31:0] sz, input int nb, input bit gaps);
      int sent = 0;
      step(1'b1, sz, 1'b0, 1'b0);
      for (int c = 0; c < 100 && sent < nb; c++) begin
         logic v;
         v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         step(1'b0, sz, v, v && (sent + 1 == nb));
         if (v) sent++;
      end
      idle(3);
   endtask

   initial begin
      rst_n  = 1'b0;
      start  = 1'b0;
      size   = '0;
      tvalid = 1'b0;
      tdata  = '0;
      tlast  = 1'b0;
      repeat (2) @(negedge clk);
      chk_reset_values("reset");
      rst_n = 1'b1;
      idle(2);

      // clean 4-word transfer, tvalid held high
      burst(32'd64, 4, 1'b0);

      // clean 4-word transfer with alternating valid
      step(1'b1, 32'd64, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++)
         step(1'b0, 32'd64, 1'(i % 2 == 0), 1'(i == 6));
      idle(3);

      // too long: 6 beats into depth 4
      burst(32'd64, 6, 1'b0);

      // too short: tlast on beat 2, then a clean start clears err
      burst(32'd64, 2, 1'b0);
      burst(32'd64, 4, 1'b0);

      // depth-0 starts are ignored even with valid data offered
      step(1'b1, 32'd0, 1'b1, 1'b0);
      step(1'b0, 32'd0, 1'b1, 1'b1);
      step(1'b1, 32'd8, 1'b1, 1'b0);
      step(1'b0, 32'd8, 1'b1, 1'b1);
      idle(2);

      // start pulse during S_RECV has no effect
      step(1'b1, 32'd64, 1'b0, 1'b0);
      step(1'b0, 32'd64, 1'b1, 1'b0);
      step(1'b1, 32'd32, 1'b1, 1'b0);
      step(1'b0, 32'd64, 1'b1, 1'b0);
      step(1'b1, 32'd64, 1'b1, 1'b1);
      idle(3);

      // randomized lengths, partial trailing words and valid gaps
      for (int t = 0; t < 25; t++) begin
         int unsigned dep;
         dep = $urandom_range(1, 6);
         burst(32'(dep * 16 + $urandom_range(0, 15)), int'($urandom_range(1, 8)), 1'b1);
      end

      // reset mid-transfer after 2 of 4 beats
      step(1'b1, 32'd64, 1'b0, 1'b0);
      step(1'b0, 32'd64, 1'b1, 1'b0);
      step(1'b0, 32'd64, 1'b1, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_values("midrst");
      mdl_busy    = 1'b0;
      mdl_discard = 1'b0;
      mdl_err     = 1'b0;
      exp_wren    = 1'b0;
      step(1'b0, 32'd64, 1'b1, 1'b0);
      step(1'b0, 32'd64, 1'b1, 1'b1);
      rst_n = 1'b1;
      step(1'b0, 32'd0, 1'b0, 1'b0);
      burst(32'd64, 4, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
